// File: rtl/datapath_control_fsm_if.sv
// Control bundle between the instruction/data memories, the control FSM and
// the 16-bit Datapath. The FSM side is the master; the Datapath/memory side
// is the slave.
interface datapath_control_fsm_if;
    logic [15:0] instr;
    logic        instr_valid;
    logic        mem_ready;
    logic        instr_req;
    logic        AluScrA;
    logic        AluSrcB;
    logic        memToReg;
    logic        jump;
    logic        branch;
    logic [1:0]  regWrite;
    logic [1:0]  exSign;
    logic [1:0]  memWrite;
    logic [3:0]  Aluop;
    logic        nest;
    logic        busy;
    logic        halted;
    logic        illegal;

    modport master (
        input  instr, instr_valid, mem_ready,
        output instr_req, AluScrA, AluSrcB, memToReg, jump, branch,
               regWrite, exSign, memWrite, Aluop, nest, busy, halted, illegal
    );

    modport slave (
        output instr, instr_valid, mem_ready,
        input  instr_req, AluScrA, AluSrcB, memToReg, jump, branch,
               regWrite, exSign, memWrite, Aluop, nest, busy, halted, illegal
    );
endinterface

// File: rtl/datapath_control_fsm.sv
// Multicycle control unit for the 16-bit Datapath: fetches an instruction
// into the IR, sequences FETCH/EXEC/MEM/WB and issues the one-cycle nest
// commit strobe. Static controls are decoded from the IR; write-type
// controls are gated to the WB cycle.
module datapath_control_fsm #(
    parameter int unsigned MULDIV_CYCLES = 4   // legal range 1..15
) (
    input  logic                   clk,
    input  logic                   reset,
    datapath_control_fsm_if.master bus
);

    typedef enum logic [2:0] {
        S_FETCH,
        S_EXEC,
        S_MEM,
        S_WB,
        S_HALT
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [15:0] r_ir;
    logic [3:0]  r_cnt;

    logic [3:0]  w_op;
    logic [3:0]  w_func;
    logic        w_is_muldiv;
    logic        w_is_load;
    logic        w_is_store;
    logic        w_is_halt;
    logic        w_is_illegal;
    logic        w_unused_ir;

    // Static decode results, valid whenever the IR holds an instruction.
    logic        w_alu_a;
    logic        w_alu_b;
    logic        w_mem_to_reg;
    logic        w_jump;
    logic        w_branch;
    logic [1:0]  w_ex_sign;
    logic [3:0]  w_aluop;
    logic [1:0]  w_reg_write;

    assign w_op         = r_ir[15:12];
    assign w_func       = r_ir[3:0];
    assign w_is_muldiv  = (w_op == 4'h0) && ((w_func == 4'h1) || (w_func == 4'h2));
    assign w_is_load    = (w_op == 4'h6);
    assign w_is_store   = (w_op == 4'h7);
    assign w_is_halt    = (w_op == 4'hF);
    assign w_is_illegal = (w_op == 4'h1) || (w_op == 4'h2) || (w_op == 4'hD) || (w_op == 4'hE);
    // Register-field bits are consumed by the Datapath, not by the decoder.
    assign w_unused_ir  = ^r_ir[11:4];

    // State register, instruction register and mul/div EXEC down-counter.
    always_ff @(posedge clk) begin
        // NOTE: state is updated with <= so every register samples the
        // pre-edge values; blocking here would create order-dependent races.
        if (reset) begin
            r_state <= S_FETCH;
            r_ir    <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == S_FETCH && bus.instr_valid) begin
                r_ir  <= bus.instr;
                r_cnt <= 4'(MULDIV_CYCLES);
            end else if (r_state == S_EXEC && r_cnt != 4'd0) begin
                r_cnt <= r_cnt - 4'd1;
            end
        end
    end

    // Opcode decode into the static control word and the WB write type.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves a
        // variable unassigned, which would otherwise infer a latch.
        w_alu_a      = 1'b1;
        w_alu_b      = 1'b1;
        w_mem_to_reg = 1'b1;
        w_jump       = 1'b1;
        w_branch     = 1'b0;
        w_ex_sign    = 2'b00;
        w_aluop      = 4'hF;
        w_reg_write  = 2'b00;
        case (w_op)
            4'h0: begin
                w_aluop = w_func;
                if (w_is_muldiv)          w_reg_write = 2'b10;
                else if (w_func != 4'h0)  w_reg_write = 2'b01;
            end
            4'h8, 4'h9, 4'hA, 4'hB: begin
                w_aluop     = w_op;
                w_alu_b     = 1'b0;
                w_ex_sign   = 2'b01;
                w_reg_write = 2'b01;
            end
            4'h3, 4'h4, 4'h5: begin
                w_aluop     = w_op;
                w_branch    = 1'b1;
                w_reg_write = 2'b11;
            end
            4'h6: begin
                w_alu_a      = 1'b0;
                w_alu_b      = 1'b0;
                w_ex_sign    = 2'b10;
                w_mem_to_reg = 1'b0;
                w_reg_write  = 2'b01;
            end
            4'h7: begin
                w_alu_a   = 1'b0;
                w_alu_b   = 1'b0;
                w_ex_sign = 2'b10;
            end
            4'hC: begin
                w_ex_sign = 2'b10;
                w_jump    = 1'b0;
            end
            default: ;
        endcase
    end

    // Next-state logic and per-state output gating.
    always_comb begin
        w_next          = r_state;
        bus.instr_req   = 1'b0;
        bus.AluScrA     = 1'b1;
        bus.AluSrcB     = 1'b1;
        bus.memToReg    = 1'b1;
        bus.jump        = 1'b1;
        bus.branch      = 1'b0;
        bus.regWrite    = 2'b00;
        bus.exSign      = 2'b00;
        bus.memWrite    = 2'b00;
        bus.Aluop       = 4'hF;
        bus.nest        = 1'b0;
        bus.busy        = 1'b0;
        bus.halted      = 1'b0;
        bus.illegal     = 1'b0;

        if (r_state == S_EXEC || r_state == S_MEM || r_state == S_WB) begin
            bus.busy     = 1'b1;
            bus.AluScrA  = w_alu_a;
            bus.AluSrcB  = w_alu_b;
            bus.memToReg = w_mem_to_reg;
            bus.jump     = w_jump;
            bus.branch   = w_branch;
            bus.exSign   = w_ex_sign;
            bus.Aluop    = w_aluop;
        end

        case (r_state)
            S_FETCH: begin
                bus.instr_req = 1'b1;
                if (bus.instr_valid) w_next = S_EXEC;
            end
            S_EXEC: begin
                bus.illegal = w_is_illegal;
                if (w_is_halt)                    w_next = S_HALT;
                else if (w_is_load || w_is_store) w_next = S_MEM;
                else if (w_is_muldiv && r_cnt > 4'd1) w_next = S_EXEC;
                else                              w_next = S_WB;
            end
            S_MEM: begin
                if (w_is_load)     bus.memWrite = 2'b10;
                if (bus.mem_ready) w_next = S_WB;
            end
            S_WB: begin
                bus.nest     = 1'b1;
                bus.regWrite = w_reg_write;
                if (w_is_store) bus.memWrite = 2'b01;
                w_next = S_FETCH;
            end
            S_HALT: begin
                bus.halted = 1'b1;
            end
            default: w_next = S_FETCH;
        endcase
    end

endmodule

// File: tb/tb_datapath_control_fsm.sv
// Scoreboard bench for datapath_control_fsm: each issued instruction pushes
// its expected commit (latency, WB control word, read cycles, illegal cycle)
// and the entry is popped and compared when nest is observed.
module tb_datapath_control_fsm;

    logic clk;
    logic reset;

    datapath_control_fsm_if bus ();

    datapath_control_fsm #(.MULDIV_CYCLES(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {AluScrA,AluSrcB,memToReg,jump,branch,regWrite,exSign,memWrite,Aluop,nest,illegal,busy}
    localparam logic [17:0] DEF_CTL = {1'b1,1'b1,1'b1,1'b1,1'b0,2'b00,2'b00,2'b00,4'hF,1'b0,1'b0,1'b0};

    typedef struct {
        logic [15:0] instr;
        int          wait_n;   // cycles mem_ready stays low in MEM
        int          lat;      // FETCH cycle (1) to nest cycle
        logic [14:0] wb;       // control word seen in the nest cycle
        int          rd_cyc;   // cycles with memWrite=10
        int          ill_cyc;  // cycle of the illegal pulse, 0 = none
    } vec_t;

    vec_t sb[$];
    vec_t tbl[10];

    int n_total = 0;
    int n_bad   = 0;

    logic [17:0] ctl;
    logic [14:0] wbv;
    assign ctl = {bus.AluScrA, bus.AluSrcB, bus.memToReg, bus.jump, bus.branch,
                  bus.regWrite, bus.exSign, bus.memWrite, bus.Aluop,
                  bus.nest, bus.illegal, bus.busy};
    assign wbv = ctl[17:3];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Issues one instruction from FETCH and follows it to its nest cycle.
    task automatic run(input vec_t v);
        int         cyc;
        int         stray;
        int         rd;
        int         ill_at;
        bit         done;
        logic [3:0] aluop0;
        vec_t       e;
        @(negedge clk);
        check($sformatf("%h_idle_ctl", v.instr), 32'(ctl), 32'(DEF_CTL));
        check($sformatf("%h_idle_req", v.instr), 32'(bus.instr_req), 32'd1);
        bus.instr       = v.instr;
        bus.instr_valid = 1'b1;
        bus.mem_ready   = 1'b0;
        sb.push_back(v);
        cyc = 1; stray = 0; rd = 0; ill_at = 0; done = 0; aluop0 = 4'h0;
        while (!done) begin
            @(negedge clk);
            bus.instr_valid = 1'b0;
            cyc++;
            bus.mem_ready = (cyc >= 3 + v.wait_n);
            if (cyc == 2) aluop0 = bus.Aluop;
            else if (bus.busy && bus.Aluop !== aluop0) stray++;
            if (bus.memWrite == 2'b10) rd++;
            if (bus.illegal) ill_at = cyc;
            if (bus.nest) begin
                e = sb.pop_front();
                check($sformatf("%h_latency", e.instr), 32'(cyc), 32'(e.lat));
                check($sformatf("%h_wb_ctl", e.instr), 32'(wbv), 32'(e.wb));
                check($sformatf("%h_rd_cycles", e.instr), 32'(rd), 32'(e.rd_cyc));
                check($sformatf("%h_illegal_at", e.instr), 32'(ill_at), 32'(e.ill_cyc));
                check($sformatf("%h_stray", e.instr), 32'(stray), 32'd0);
                done = 1;
            end else if (bus.regWrite != 2'b00 || bus.memWrite == 2'b01) begin
                stray++;
            end
            if (!done && cyc > 40) begin
                check($sformatf("%h_timeout", v.instr), 32'(cyc), 32'(v.lat));
                done = 1;
            end
        end
        bus.mem_ready = 1'b0;
    endtask

    initial begin
        int nests;
        //        instr     wait lat  {A,B,m2r,j,br,rw,   ex,   mw,   op}                                rd ill
        tbl[0] = '{16'h012E, 0, 3, {1'b1,1'b1,1'b1,1'b1,1'b0,2'b01,2'b00,2'b00,4'hE}, 0, 0};
        tbl[1] = '{16'h0121, 0, 6, {1'b1,1'b1,1'b1,1'b1,1'b0,2'b10,2'b00,2'b00,4'h1}, 0, 0};
        tbl[2] = '{16'h0000, 0, 3, {1'b1,1'b1,1'b1,1'b1,1'b0,2'b00,2'b00,2'b00,4'h0}, 0, 0};
        tbl[3] = '{16'hA105, 0, 3, {1'b1,1'b0,1'b1,1'b1,1'b0,2'b01,2'b01,2'b00,4'hA}, 0, 0};
        tbl[4] = '{16'h6210, 2, 6, {1'b0,1'b0,1'b0,1'b1,1'b0,2'b01,2'b10,2'b00,4'hF}, 3, 0};
        tbl[5] = '{16'h7210, 0, 4, {1'b0,1'b0,1'b1,1'b1,1'b0,2'b00,2'b10,2'b01,4'hF}, 0, 0};
        tbl[6] = '{16'h3120, 0, 3, {1'b1,1'b1,1'b1,1'b1,1'b1,2'b11,2'b00,2'b00,4'h3}, 0, 0};
        tbl[7] = '{16'h5000, 0, 3, {1'b1,1'b1,1'b1,1'b1,1'b1,2'b11,2'b00,2'b00,4'h5}, 0, 0};
        tbl[8] = '{16'hC123, 0, 3, {1'b1,1'b1,1'b1,1'b0,1'b0,2'b00,2'b10,2'b00,4'hF}, 0, 0};
        tbl[9] = '{16'hD000, 0, 3, {1'b1,1'b1,1'b1,1'b1,1'b0,2'b00,2'b00,2'b00,4'hF}, 0, 2};

        reset = 1'b1;
        bus.instr = 16'h0000;
        bus.instr_valid = 1'b0;
        bus.mem_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_ctl", 32'(ctl), 32'(DEF_CTL));
        check("reset_req", 32'(bus.instr_req), 32'd1);
        check("reset_halted", 32'(bus.halted), 32'd0);
        reset = 1'b0;

        foreach (tbl[i]) run(tbl[i]);

        // instr_valid held high: ALU op commits every 3 cycles; valid pulses
        // outside FETCH must not start anything.
        @(negedge clk);
        bus.instr = 16'h012E;
        bus.instr_valid = 1'b1;
        nests = 0;
        for (int c = 1; c <= 9; c++) begin
            if (bus.nest) nests++;
            @(negedge clk);
        end
        if (bus.nest) nests++;
        check("b2b_nest_count", 32'(nests), 32'd3);
        bus.instr_valid = 1'b0;
        repeat (3) @(negedge clk);

        // Halt: parks in HALT with no request and no commit until reset.
        check("pre_halt_req", 32'(bus.instr_req), 32'd1);
        bus.instr = 16'hF000;
        bus.instr_valid = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("halt_halted", 32'(bus.halted), 32'd1);
        check("halt_req", 32'(bus.instr_req), 32'd0);
        check("halt_busy", 32'(bus.busy), 32'd0);
        nests = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (bus.nest || !bus.halted) nests++;
        end
        check("halt_stays", 32'(nests), 32'd0);
        bus.instr_valid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("halt_reset_halted", 32'(bus.halted), 32'd0);
        check("halt_reset_req", 32'(bus.instr_req), 32'd1);

        // Reset while a load waits in MEM.
        bus.instr = 16'h6210;
        bus.instr_valid = 1'b1;
        @(negedge clk);
        bus.instr_valid = 1'b0;
        @(negedge clk);
        check("rst_mem_rd", 32'(bus.memWrite), 32'd2);
        reset = 1'b1;
        @(negedge clk);
        check("rst_mem_ctl", 32'(ctl), 32'(DEF_CTL));
        check("rst_mem_req", 32'(bus.instr_req), 32'd1);
        reset = 1'b0;

        // Machine resumes normally after the aborted load.
        run(tbl[0]);
        check("sb_empty", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/datapath_control_fsm.md
Name: datapath_control_fsm

Overview:
- Multicycle control unit that sits directly upstream of the 16-bit Datapath and drives all of its control inputs.
- Handshakes with instruction memory to fetch a 16-bit instruction and latches it into an internal instruction register (IR).
- Sequences FETCH/EXEC/MEM/WB for each instruction.
- Issues the one-cycle `nest` commit strobe that the Datapath uses to advance and commit an instruction.

Parameters:
MULDIV_CYCLES, 4, EXEC cycles for R-type func 0001/0010 (multiply/divide); legal range 1..15

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
instr  input  16  instruction word from instruction memory
instr_valid  input  1  instr is valid this cycle
mem_ready  input  1  data memory has completed the access this cycle
instr_req  output  1  fetch request, high only in FETCH
AluScrA  output  1  ALU A select: 1 = register, 0 = base/PC
AluSrcB  output  1  ALU B select: 1 = register, 0 = extended immediate
memToReg  output  1  1 = ALU result, 0 = memory data
jump  output  1  1 = sequential PC, 0 = jump target
branch  output  1  branch compare active
regWrite  output  2  00 none, 01 single write, 10 dual write (R0 receives upper/remainder), 11 compare-only/no write
exSign  output  2  00 none, 01 sign-extend imm8, 10 zero-extend imm8, 11 reserved
memWrite  output  2  00 idle, 01 write, 10 read
Aluop  output  4  ALU operation
nest  output  1  one-cycle instruction-commit strobe
busy  output  1  high in any state except FETCH and HALT
halted  output  1  high in HALT
illegal  output  1  one-cycle pulse on an undefined opcode

Behaviour:
- Reset defaults, also driven in FETCH and HALT: AluScrA=1, AluSrcB=1, memToReg=1, jump=1, branch=0, regWrite=00, exSign=00, memWrite=00, Aluop=F, nest=0, illegal=0, busy=0.
- instr_req=1 only in FETCH.
- Reset mid-instruction:
  - Next edge enters FETCH with the defaults.
  - No nest is issued, no regWrite is issued, and the IR is cleared to 0.
- States: FETCH, EXEC, MEM, WB, HALT.
- FETCH:
  - Waits while instr_valid=0.
  - On instr_valid=1: latches IR=instr and goes to EXEC.
- Decode is combinational from IR; IR[15:12] is the opcode.
  - 0000 R-type:
    - Aluop=IR[3:0], AluScrA=1, AluSrcB=1, memToReg=1.
    - func 0001/0010: regWrite=10 in WB; EXEC lasts MULDIV_CYCLES cycles, counted by a 4-bit down-counter loaded on FETCH exit.
    - func 0000: NOP, regWrite=00 in WB.
    - All other funcs: regWrite=01 in WB.
  - 1000/1001/1010/1011 immediate ALU:
    - Aluop=opcode, AluSrcB=0, exSign=01, memToReg=1.
    - regWrite=01 in WB.
  - 0011/0100/0101 branch:
    - Aluop=3/4/5 respectively, branch=1, AluSrcB=1.
    - regWrite=11 in WB.
  - 0110 load:
    - AluScrA=0, AluSrcB=0, exSign=10, Aluop=F, memToReg=0.
    - memWrite=10 in MEM; regWrite=01 in WB.
  - 0111 store:
    - Same address path as load.
    - memWrite=00 in MEM; memWrite=01 in WB only.
  - 1100 jump:
    - exSign=10, jump=0 held EXEC..WB.
    - regWrite=00.
  - 1111 halt: EXEC → HALT. HALT is left only by reset. nest is not issued.
  - 0001/0010/1101/1110 illegal:
    - illegal=1 in EXEC.
    - Executes as NOP and still commits with nest in WB.
- Output rules:
  - Static controls (AluScrA, AluSrcB, memToReg, jump, branch, exSign, Aluop) are held constant from EXEC through WB.
  - regWrite, nest, and memWrite=01 are asserted only in WB, for exactly one cycle.
- Transitions:
  - EXEC → MEM for load/store.
  - EXEC → WB for all others, after the counter expires for mul/div.
  - MEM waits until mem_ready=1, then goes to WB.
  - WB → FETCH unconditionally.
- Latency, from the FETCH cycle with instr_valid=1 to the nest cycle: ALU/imm/branch/jump = 3 cycles; load/store = 4 + (mem_ready wait) cycles; mul/div = 2 + MULDIV_CYCLES cycles.
- Back-to-back instructions: instr_valid held high gives nest every 3 cycles for ALU ops. An instr_valid pulse outside FETCH is ignored.

Test Plan:
- Reset=1 for 2 cycles, then instr_valid=1, instr=0x012E → nest=1 in cycle 3 with Aluop=E, regWrite=01, memToReg=1; all defaults restored in cycle 4.
- MULDIV_CYCLES=4, instr=0x0121 → regWrite=10 and nest in cycle 6; Aluop=1 stable for cycles 2–6.
- instr=0xA105 → exSign=01, AluSrcB=0, Aluop=A; nest and regWrite=01 in cycle 3. instr=0x6210 with mem_ready low for 2 cycles → memWrite=10 held for 3 cycles, then regWrite=01, memToReg=0, nest.
- instr=0x7210 → memWrite=01 only in the nest cycle. instr=0x3120 → branch=1, regWrite=11, Aluop=3 in WB.
- instr=0xD000 → illegal pulse in cycle 2, nest in cycle 3. instr=0xF000 → halted=1, instr_req=0, no nest until reset.
- Assert reset during a load's MEM state → next cycle in FETCH with all defaults and no nest pulse.
